// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: fixed-priority or round-robin grant, one turnaround cycle
// between owners, and a watchdog that forces completion of a stalled transfer.
module bus_arbiter #(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 256,
  localparam int unsigned IW = $clog2(MASTERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] bus_req,
  output logic [MASTERS-1:0] bus_grant,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               fc_abort,
  output logic               bus_busy,
  output logic [IW-1:0]      owner,
  output logic               err_valid,
  output logic [IW-1:0]      err_master
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e             state_q;
  logic [MASTERS-1:0] grant_q;
  logic               busy_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      last_q;
  logic [CW-1:0]      wd_cnt_q;
  logic               fc_abort_q;
  logic               err_valid_q;
  logic [IW-1:0]      err_master_q;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic [MASTERS-1:0] win_onehot;

  // Scan candidates in priority order; round-robin starts just past the last owner.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (RR_MODE != 0) begin
        cand = IW'((32'(last_q) + 32'(i) + 32'd1) % MASTERS);
      end else begin
        cand = IW'(i);
      end
      if (!win_found && bus_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      owner_q      <= '0;
      last_q       <= IW'(MASTERS - 1);
      wd_cnt_q     <= '0;
      fc_abort_q   <= 1'b0;
      err_valid_q  <= 1'b0;
      err_master_q <= '0;
    end else begin
      fc_abort_q  <= 1'b0;
      err_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          wd_cnt_q <= '0;
          if (win_found) begin
            owner_q <= win_idx;
            grant_q <= win_onehot;
            busy_q  <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (!bus_req[owner_q]) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            last_q   <= owner_q;
            wd_cnt_q <= '0;
            state_q  <= StTurn;
          end else if (fc_bus) begin
            // Real completion beats an abort due on the same edge.
            wd_cnt_q <= '0;
          end else if ((TIMEOUT != 0) && (wd_cnt_q == TimeoutVal)) begin
            wd_cnt_q     <= '0;
            fc_abort_q   <= 1'b1;
            err_valid_q  <= 1'b1;
            err_master_q <= owner_q;
          end else if ((TIMEOUT != 0) && (rd_bus || wr_bus) && (wd_cnt_q != {CW{1'b1}})) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
          end
        end
        StTurn: begin
          wd_cnt_q <= '0;
          state_q  <= StIdle;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_grant  = grant_q;
  assign bus_busy   = busy_q;
  assign owner      = owner_q;
  assign fc_abort   = fc_abort_q;
  assign err_valid  = err_valid_q;
  assign err_master = err_master_q;

endmodule
